mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - big-endian byte/half/word memory stage with MFA/MFC handshake
module mem_access_unit #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mfa,
    input  logic        i_mop_rw,
    input  logic [1:0]  i_msize,
    input  logic        i_msign,
    input  logic [31:0] i_mar,
    input  logic [31:0] i_mdr,
    output logic [31:0] o_data_out,
    output logic        o_mfc,
    output logic        o_mae,
    output logic        o_busy
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

    logic [7:0] ram [0:(1 << ADDR_W) - 1];

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [1:0]        r_size;
    logic              r_sign;
    logic              r_err;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_idx;
    logic [31:0]       r_shift;

    logic              w_illegal;
    logic [1:0]        w_last_idx;
    logic              w_last;
    logic [ADDR_W-1:0] w_ptr;
    logic [7:0]        w_rd_byte;
    logic [31:0]       w_asm;
    logic [31:0]       w_ext;
    logic [31:0]       w_store_aligned;
    logic              w_busy_nxt;
    logic              w_mfc_nxt;
    logic              w_mae_nxt;
    logic [31:0]       w_data_nxt;
    logic              w_unused;

    assign w_unused   = ^i_mar[31:ADDR_W];
    assign w_illegal  = (i_msize == 2'b11)
                     || (i_msize == 2'b01 && i_mar[0])
                     || (i_msize == 2'b10 && i_mar[1:0] != 2'b00);
    assign w_last_idx = (r_size == 2'b00) ? 2'd0 : (r_size == 2'b01) ? 2'd1 : 2'd3;
    assign w_last     = (r_idx == w_last_idx);
    assign w_ptr      = r_addr + ADDR_W'(r_idx);
    assign w_rd_byte  = ram[w_ptr];
    // One shift register serves both directions: stores pop the MSB, loads push bytes in at the LSB.
    assign w_asm      = {r_shift[23:0], w_rd_byte};

    always_comb begin
        w_store_aligned = i_mdr;
        case (i_msize)
            2'b00:   w_store_aligned = {i_mdr[7:0], 24'h0};
            2'b01:   w_store_aligned = {i_mdr[15:0], 16'h0};
            default: w_store_aligned = i_mdr;
        endcase
    end

    always_comb begin
        w_ext = w_asm;
        case (r_size)
            2'b00:   w_ext = {{24{r_sign & w_asm[7]}}, w_asm[7:0]};
            2'b01:   w_ext = {{16{r_sign & w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_mfa) w_next = w_illegal ? S_DONE : ((WAIT_CYCLES == 0) ? S_XFER : S_WAIT);
            S_WAIT: if (r_cnt == CW'(1)) w_next = S_XFER;
            S_XFER: if (w_last) w_next = S_DONE;
            S_DONE: if (o_mfc && !i_mfa) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // MFC is raised one edge after entering DONE, and DONE is held until MFC has actually been shown.
    always_comb begin
        w_busy_nxt = (w_next == S_WAIT) || (w_next == S_XFER);
        w_mfc_nxt  = (r_state == S_DONE) && (w_next == S_DONE);
        w_mae_nxt  = w_mfc_nxt && r_err;
        w_data_nxt = (r_state == S_XFER && w_last && r_rw) ? w_ext : o_data_out;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_rw       <= 1'b0;
            r_size     <= 2'b00;
            r_sign     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_shift    <= 32'h0;
            o_data_out <= 32'h0;
            o_mfc      <= 1'b0;
            o_mae      <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_data_out <= w_data_nxt;
            o_mfc      <= w_mfc_nxt;
            o_mae      <= w_mae_nxt;
            o_busy     <= w_busy_nxt;
            if (r_state == S_IDLE && i_mfa) begin
                r_addr  <= i_mar[ADDR_W-1:0];
                r_rw    <= i_mop_rw;
                r_size  <= i_msize;
                r_sign  <= i_msign;
                r_err   <= w_illegal;
                r_cnt   <= CW'(WAIT_CYCLES);
                r_idx   <= 2'd0;
                r_shift <= w_store_aligned;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end else if (r_state == S_XFER) begin
                r_idx   <= r_idx + 2'd1;
                r_shift <= w_asm;
            end
        end
    end

    // No reset on the array: contents survive reset, and r_state is forced to IDLE so no write occurs.
    always_ff @(posedge i_clk) begin
        if (r_state == S_XFER && !r_rw)
            ram[w_ptr] <= r_shift[31:24];
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with a byte-array reference model
module tb_mem_access_unit;
    localparam int AW    = 9;
    localparam int W     = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mfa = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign = 1'b0;
    logic [31:0] mar = 32'h0;
    logic [31:0] mdr = 32'h0;
    logic [31:0] dout;
    logic        mfc;
    logic        mae;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0]  model_mem [DEPTH];
    logic [31:0] model_dout = 32'h0;

    mem_access_unit #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mfa(mfa), .i_mop_rw(rw), .i_msize(size),
        .i_msign(sign), .i_mar(mar), .i_mdr(mdr),
        .o_data_out(dout), .o_mfc(mfc), .o_mae(mae), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int nb, input logic sg);
        longint v = 0;
        for (int i = 0; i < nb; i++) v = v * 256 + longint'(model_mem[(addr + i) % DEPTH]);
        if (sg && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] addr, input int nb, input logic [31:0] wd);
        for (int i = 0; i < nb; i++) model_mem[(addr + i) % DEPTH] = 8'((wd >> (8 * (nb - 1 - i))) & 32'hFF);
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.ram[i] !== model_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic access(input logic r, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold, input string tag);
        int  n = 0;
        int  busy_n = 0;
        int  hold_n = 0;
        bit  seen = 0;
        bit  illegal;
        int  nb;
        illegal = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        @(negedge clk);
        rw = r; size = sz; sign = sg; mar = addr; mdr = wd; mfa = 1'b1;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_n++;
            if (mfc) seen = 1;
        end
        if (!illegal && r) model_dout = model_load(addr, nb, sg);
        if (!illegal && !r) model_store(addr, nb, wd);
        check({tag, " mfc_edge"}, n, illegal ? 2 : W + nb + 2);
        check({tag, " busy_cycles"}, busy_n, illegal ? 0 : W + nb);
        check({tag, " mae"}, {31'h0, mae}, {31'h0, illegal});
        check({tag, " data_out"}, dout, model_dout);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (mfc && !busy) hold_n++;
        end
        if (hold > 0) check({tag, " mfc_hold"}, hold_n, hold);
        @(negedge clk);
        mfa = 1'b0;
        @(posedge clk); #1;
        check({tag, " release"}, {29'h0, mfc, mae, busy}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = 8'($urandom);
            dut.ram[i]   = model_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {29'h0, mfc, mae, busy}, 32'h0);
        check("reset data_out", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 2'b10, 1'b0, 32'h004, 32'hA2044012, 0, "st_word");
        check("ram[4..7]", {dut.ram[4], dut.ram[5], dut.ram[6], dut.ram[7]}, 32'hA2044012);
        access(1'b1, 2'b10, 1'b0, 32'h004, 32'h0, 0, "ld_word");
        check("ld_word const", dout, 32'hA2044012);

        model_mem[16] = 8'h9C;
        dut.ram[16]   = 8'h9C;
        access(1'b1, 2'b00, 1'b1, 32'h010, 32'h0, 0, "ld_byte_s");
        check("ld_byte_s const", dout, 32'hFFFFFF9C);
        access(1'b1, 2'b00, 1'b0, 32'h010, 32'h0, 0, "ld_byte_u");
        check("ld_byte_u const", dout, 32'h0000009C);

        access(1'b0, 2'b01, 1'b0, 32'h1FE, 32'h1234ABCD, 0, "st_half_top");
        check("ram[1FE..1FF]", {16'h0, dut.ram[9'h1FE], dut.ram[9'h1FF]}, 32'h0000ABCD);
        check_ram("ram after top half");

        access(1'b0, 2'b10, 1'b0, 32'h006, 32'hFFFFFFFF, 0, "mis_word");
        access(1'b1, 2'b11, 1'b1, 32'h008, 32'h0, 0, "size11");
        check("data held after errors", dout, 32'h0000009C);
        check_ram("ram after errors");

        access(1'b1, 2'b01, 1'b1, 32'h1FE, 32'h0, 10, "hold10");

        for (int t = 0; t < 24; t++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = $urandom;
            s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) a = a & ~((s == 2'b10) ? 32'h3 : (s == 2'b01) ? 32'h1 : 32'h0);
            access(1'($urandom), s, 1'($urandom), a, $urandom, $urandom_range(0, 2), $sformatf("rnd%0d", t));
        end
        check_ram("ram after random");

        @(negedge clk);
        rw = 1'b0; size = 2'b10; sign = 1'b0; mar = 32'h020; mdr = 32'hDEADBEEF; mfa = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mfa = 1'b0;
        model_mem[32] = 8'hDE;
        model_mem[33] = 8'hAD;
        model_dout = 32'h0;
        check("midreset outputs", {29'h0, mfc, mae, busy}, 32'h0);
        check("midreset data_out", dout, 32'h0);
        check("midreset ram[20..21]", {16'h0, dut.ram[32], dut.ram[33]}, 32'h0000DEAD);
        check("midreset ram[22..23]", {16'h0, dut.ram[34], dut.ram[35]}, {16'h0, model_mem[34], model_mem[35]});
        check("midreset state", {30'h0, dut.r_state}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 0, "ld_after_reset");
        check_ram("ram final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
